// File: rtl/inc_dec_counter_mod13_mod7.sv
// Up/down event counter: increments wrap modulo 13, decrements wrap 0 -> 6.
// Define INC_DEC_EDGE_DETECT_EN to count rising edges of inc/dec instead of levels.
module inc_dec_counter_mod13_mod7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] cnt
);

    localparam logic [3:0] CNT_MAX  = 4'd12;
    localparam logic [3:0] DEC_WRAP = 4'd6;

    logic       inc_eff;
    logic       dec_eff;
    logic [3:0] cnt_next;

`ifdef INC_DEC_EDGE_DETECT_EN
    logic inc_q;
    logic dec_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
        end
    end

    // Only a 0->1 transition counts, so a held strobe gives exactly one step.
    assign inc_eff = inc & ~inc_q;
    assign dec_eff = dec & ~dec_q;
`else
    assign inc_eff = inc;
    assign dec_eff = dec;
`endif

    always_comb begin
        cnt_next = cnt;
        if (cnt > CNT_MAX) begin
            // Out-of-range state recovers to 0 on the next edge, whatever the request.
            cnt_next = 4'd0;
        end else if (inc_eff && !dec_eff) begin
            cnt_next = (cnt == CNT_MAX) ? 4'd0 : cnt + 4'd1;
        end else if (dec_eff && !inc_eff) begin
            cnt_next = (cnt == 4'd0) ? DEC_WRAP : cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_inc_dec_counter_mod13_mod7.sv
// Directed-vector bench for inc_dec_counter_mod13_mod7 (level or edge build).
module tb_inc_dec_counter_mod13_mod7;

    logic       clk;
    logic       rst;
    logic       inc;
    logic       dec;
    logic [3:0] cnt;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       inc;
        logic       dec;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];

    inc_dec_counter_mod13_mod7 dut (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .dec (dec),
        .cnt (cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cnt=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic i, input logic d);
        @(negedge clk);
        inc = i;
        dec = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic i, input logic d, input logic [3:0] exp, input string name);
        drive(i, d);
        check(name, cnt, exp);
        drive(1'b0, 1'b0);
        check({name, "_idle"}, cnt, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_async", cnt, 4'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [3:0] model(input logic [3:0] cur, input logic i, input logic d);
        if (i && !d) return (cur == 4'd12) ? 4'd0 : cur + 4'd1;
        if (d && !i) return (cur == 4'd0) ? 4'd6 : cur - 4'd1;
        return cur;
    endfunction

    function automatic void add(input logic i, input logic d, input logic [3:0] e);
        vec_t v;
        v.inc = i;
        v.dec = d;
        v.exp = e;
        vecs.push_back(v);
        v.inc = 1'b0;
        v.dec = 1'b0;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] m;
        n_checks = 0;
        n_fail   = 0;
        inc = 1'b0;
        dec = 1'b0;
        rst = 1'b0;

        // Hand-computed pulse table (each pulse followed by an idle cycle).
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b0, 4'(k));
        for (int k = 9; k >= 3; k--)  add(1'b0, 1'b1, 4'(k));
        add(1'b1, 1'b0, 4'd4);
        add(1'b1, 1'b0, 4'd5);
        add(1'b1, 1'b1, 4'd5);

        #1;
        check("reset_init", cnt, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", cnt, 4'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].inc, vecs[k].dec);
            check($sformatf("vec%0d", k), cnt, vecs[k].exp);
        end

        // Up to 12, then wrap to 0 and decrement-wrap to 6.
        for (int k = 6; k <= 12; k++) pulse(1'b1, 1'b0, 4'(k), "climb");
        pulse(1'b1, 1'b0, 4'd0, "inc_wrap_12_to_0");
        pulse(1'b0, 1'b1, 4'd6, "dec_wrap_0_to_6");

        // Back to 0, then 13 increments return to 0.
        for (int k = 5; k >= 0; k--) pulse(1'b0, 1'b1, 4'(k), "descend");
        for (int k = 1; k <= 13; k++) pulse(1'b1, 1'b0, (k == 13) ? 4'd0 : 4'(k), "mod13_lap");
        check("mod13_lap_end", cnt, 4'd0);

        // Async reset between edges with cnt = 9.
        for (int k = 1; k <= 9; k++) pulse(1'b1, 1'b0, 4'(k), "to_nine");
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_mid", cnt, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        pulse(1'b1, 1'b0, 4'd1, "inc_after_reset");

        // Held increment: level counts every cycle, edge mode counts once.
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
`ifdef INC_DEC_EDGE_DETECT_EN
        check("inc_held_4", cnt, 4'd1);
`else
        check("inc_held_4", cnt, 4'd4);
`endif
        drive(1'b0, 1'b0);
`ifdef INC_DEC_EDGE_DETECT_EN
        check("inc_held_release", cnt, 4'd1);
`else
        check("inc_held_release", cnt, 4'd4);
`endif

        // Random separated pulses against the reference model.
        do_reset();
        m = 4'd0;
        for (int k = 0; k < 40; k++) begin
            int sel;
            logic ri;
            logic rd;
            sel = $urandom_range(0, 3);
            ri  = (sel == 1) || (sel == 3);
            rd  = (sel == 2) || (sel == 3);
            m   = model(m, ri, rd);
            exp_q.push_back(m);
            drive(ri, rd);
            check($sformatf("rand%0d", k), cnt, exp_q.pop_front());
            drive(1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
